// File: rtl/bp_me_io_arb_pkg.sv
// Shared types for the I/O loader arbiter: grant-mode enum and an index-width helper.
package bp_me_io_arb_pkg;

  typedef enum logic [0:0] {
    e_io_arb_fixed = 1'b0,
    e_io_arb_rr    = 1'b1
  } bp_io_arb_mode_e;

  // Index width that stays at least one bit for single-entry ranges
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_me_io_loader_arbiter_tracker.sv
// In-order tracker of issuing-source ids for in-flight I/O commands (small 1r1w FIFO).
module bp_me_io_loader_arbiter_tracker
  import bp_me_io_arb_pkg::*;
#(
  parameter int width_p = 1,
  parameter int els_p   = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [width_p-1:0]           data_i,
  input  logic                         v_i,
  input  logic                         yumi_i,
  output logic [width_p-1:0]           data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  localparam int ptr_w_lp = idx_width(els_p);
  localparam int cnt_w_lp = $clog2(els_p+1);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p-1);
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (v_i) begin
      wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + 1'b1;
    end else begin
      wptr_d = wptr_q;
    end
    if (yumi_i) begin
      rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + 1'b1;
    end else begin
      rptr_d = rptr_q;
    end
    // Simultaneous enqueue and dequeue leave the occupancy unchanged
    case ({v_i, yumi_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (v_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign full_o  = (cnt_q == full_cnt_lp);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/bp_me_io_loader_arbiter.sv
// N-source arbiter for loader traffic onto one I/O channel, with grant holding
// under backpressure and in-order routing of responses back to the issuer.
module bp_me_io_loader_arbiter
  import bp_me_io_arb_pkg::*;
#(
  parameter int num_src_p         = 2,
  parameter int io_msg_width_p    = 128,
  parameter int max_outstanding_p = 4,
  parameter int rr_mode_p         = 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_src_p-1:0]                  src_en_i,
  input  logic [num_src_p*io_msg_width_p-1:0]   src_cmd_i,
  input  logic [num_src_p-1:0]                  src_cmd_v_i,
  output logic [num_src_p-1:0]                  src_cmd_ready_o,
  output logic [num_src_p*io_msg_width_p-1:0]   src_resp_o,
  output logic [num_src_p-1:0]                  src_resp_v_o,
  input  logic [num_src_p-1:0]                  src_resp_ready_i,
  output logic [io_msg_width_p-1:0]             io_cmd_o,
  output logic                                  io_cmd_v_o,
  input  logic                                  io_cmd_ready_i,
  input  logic [io_msg_width_p-1:0]             io_resp_i,
  input  logic                                  io_resp_v_i,
  output logic                                  io_resp_yumi_o,
  output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
  output logic                                  error_o
);

  localparam int sw_lp = idx_width(num_src_p);
  localparam bp_io_arb_mode_e mode_lp = (rr_mode_p != 0) ? e_io_arb_rr : e_io_arb_fixed;
  localparam logic [sw_lp-1:0] last_src_lp = sw_lp'(num_src_p-1);

  logic [io_msg_width_p-1:0] cmd_arr [num_src_p];
  logic [num_src_p-1:0]      eligible_s;
  logic [sw_lp-1:0]          rr_ptr_q, rr_ptr_d, hold_idx_q, hold_idx_d;
  logic [sw_lp-1:0]          arb_idx_s, grant_idx_s, trk_head_s;
  logic                      hold_v_q, hold_v_d, hold_ok_s, arb_found_s;
  logic                      error_q, error_d;
  logic                      trk_full_s, trk_empty_s, accept_s, resp_v_s;

  for (genvar s = 0; s < num_src_p; s++) begin : g_cmd
    assign cmd_arr[s] = src_cmd_i[s*io_msg_width_p +: io_msg_width_p];
  end

  assign eligible_s = src_cmd_v_i & src_en_i;

  // Search starts at the RR pointer (or at 0 in fixed mode) and wraps
  always_comb begin
    int         cand;
    logic [sw_lp-1:0] cand_idx;
    cand        = 0;
    cand_idx    = '0;
    arb_found_s = 1'b0;
    arb_idx_s   = '0;
    for (int i = 0; i < num_src_p; i++) begin
      cand     = (mode_lp == e_io_arb_rr) ? (int'(rr_ptr_q) + i) % num_src_p : i;
      cand_idx = cand[sw_lp-1:0];
      if (!arb_found_s && eligible_s[cand_idx]) begin
        arb_found_s = 1'b1;
        arb_idx_s   = cand_idx;
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  // A stalled grant sticks while its source stays valid and enabled
  assign hold_ok_s   = hold_v_q & eligible_s[hold_idx_q];
  assign grant_idx_s = hold_ok_s ? hold_idx_q : arb_idx_s;
  assign io_cmd_v_o  = ~reset_i & (hold_ok_s | arb_found_s) & ~trk_full_s;
  assign io_cmd_o    = cmd_arr[grant_idx_s];
  assign accept_s    = io_cmd_v_o & io_cmd_ready_i;

  assign resp_v_s       = ~reset_i & io_resp_v_i & ~trk_empty_s;
  assign io_resp_yumi_o = resp_v_s & src_resp_ready_i[trk_head_s];
  assign src_resp_o     = {num_src_p{io_resp_i}};

  always_comb begin
    src_cmd_ready_o = '0;
    src_resp_v_o    = '0;
    if (io_cmd_v_o) begin
      src_cmd_ready_o[grant_idx_s] = io_cmd_ready_i;
    end else begin
      src_cmd_ready_o = '0;
    end
    src_resp_v_o[trk_head_s] = resp_v_s;
  end

  always_comb begin
    hold_v_d   = io_cmd_v_o & ~io_cmd_ready_i;
    hold_idx_d = grant_idx_s;
    error_d    = error_q | (io_resp_v_i & trk_empty_s);
    if (accept_s) begin
      rr_ptr_d = (grant_idx_s == last_src_lp) ? '0 : grant_idx_s + 1'b1;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_q   <= '0;
      hold_v_q   <= 1'b0;
      hold_idx_q <= '0;
      error_q    <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      hold_v_q   <= hold_v_d;
      hold_idx_q <= hold_idx_d;
      error_q    <= error_d;
    end
  end

  assign error_o = error_q;

  bp_me_io_loader_arbiter_tracker #(
    .width_p (sw_lp),
    .els_p   (max_outstanding_p)
  ) tracker (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (grant_idx_s),
    .v_i     (accept_s),
    .yumi_i  (io_resp_yumi_o),
    .data_o  (trk_head_s),
    .full_o  (trk_full_s),
    .empty_o (trk_empty_s),
    .count_o (outstanding_o)
  );

endmodule

// File: tb/tb_bp_me_io_loader_arbiter.sv
// Directed bench: a round-robin instance (3 sources, depth 2) and a fixed-priority
// instance (3 sources, depth 4) share one set of stimulus.
module tb_bp_me_io_loader_arbiter;

  localparam int N = 3;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [N-1:0]     src_en, src_cmd_v, src_resp_ready;
  logic [N*W-1:0]   src_cmd;
  logic             io_cmd_ready, io_resp_v;
  logic [W-1:0]     io_resp;

  logic [N-1:0]     r_cmd_rdy, r_resp_v, f_cmd_rdy, f_resp_v;
  logic [N*W-1:0]   r_resp, f_resp;
  logic [W-1:0]     r_cmd, f_cmd;
  logic             r_cmd_v, r_yumi, r_err, f_cmd_v, f_yumi, f_err;
  logic [1:0]       r_out;
  logic [2:0]       f_out;

  logic [W-1:0]     exp_msg [N];
  int vecs = 0;
  int miss = 0;

  bp_me_io_loader_arbiter #(.num_src_p(N), .io_msg_width_p(W), .max_outstanding_p(2), .rr_mode_p(1)) dut_rr (
    .clk_i(clk), .reset_i(reset), .src_en_i(src_en), .src_cmd_i(src_cmd), .src_cmd_v_i(src_cmd_v),
    .src_cmd_ready_o(r_cmd_rdy), .src_resp_o(r_resp), .src_resp_v_o(r_resp_v),
    .src_resp_ready_i(src_resp_ready), .io_cmd_o(r_cmd), .io_cmd_v_o(r_cmd_v),
    .io_cmd_ready_i(io_cmd_ready), .io_resp_i(io_resp), .io_resp_v_i(io_resp_v),
    .io_resp_yumi_o(r_yumi), .outstanding_o(r_out), .error_o(r_err));

  bp_me_io_loader_arbiter #(.num_src_p(N), .io_msg_width_p(W), .max_outstanding_p(4), .rr_mode_p(0)) dut_fp (
    .clk_i(clk), .reset_i(reset), .src_en_i(src_en), .src_cmd_i(src_cmd), .src_cmd_v_i(src_cmd_v),
    .src_cmd_ready_o(f_cmd_rdy), .src_resp_o(f_resp), .src_resp_v_o(f_resp_v),
    .src_resp_ready_i(src_resp_ready), .io_cmd_o(f_cmd), .io_cmd_v_o(f_cmd_v),
    .io_cmd_ready_i(io_cmd_ready), .io_resp_i(io_resp), .io_resp_v_i(io_resp_v),
    .io_resp_yumi_o(f_yumi), .outstanding_o(f_out), .error_o(f_err));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    src_cmd_v      = '0;
    io_cmd_ready   = 1'b0;
    io_resp_v      = 1'b0;
    src_resp_ready = '0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    exp_msg[0] = 16'h00A0;
    exp_msg[1] = 16'h00B0;
    exp_msg[2] = 16'h00C0;
    src_cmd        = {16'h00C0, 16'h00B0, 16'h00A0};
    reset          = 1'b1;
    src_en         = '0;
    src_cmd_v      = '0;
    src_resp_ready = '0;
    io_cmd_ready   = 1'b0;
    io_resp_v      = 1'b0;
    io_resp        = 16'h0000;
    tick();
    tick();

    // Reset: every valid/ready low even with all inputs asserted
    src_en = 3'b111; src_cmd_v = 3'b111; io_cmd_ready = 1'b1;
    io_resp_v = 1'b1; src_resp_ready = 3'b111;
    settle();
    chk("rst_cmd_v", r_cmd_v, 1'b0);
    chk("rst_cmd_rdy", r_cmd_rdy, 3'b000);
    chk("rst_resp_v", r_resp_v, 3'b000);
    chk("rst_yumi", r_yumi, 1'b0);
    chk("rst_out", r_out, 2'd0);
    chk("rst_err", r_err, 1'b0);
    chk("rst_fp_cmd_v", f_cmd_v, 1'b0);
    tick();
    do_reset();

    // Fixed priority: src 0 wins while valid, then 1, then 2
    src_en = 3'b111; src_cmd_v = 3'b111; io_cmd_ready = 1'b1;
    settle();
    chk("fp_c0_cmd", f_cmd, 16'h00A0);
    chk("fp_c0_rdy", f_cmd_rdy, 3'b001);
    tick();
    settle();
    chk("fp_c1_cmd", f_cmd, 16'h00A0);
    chk("fp_c1_rdy", f_cmd_rdy, 3'b001);
    tick();
    src_cmd_v = 3'b110;
    settle();
    chk("fp_c2_cmd", f_cmd, 16'h00B0);
    chk("fp_c2_rdy", f_cmd_rdy, 3'b010);
    tick();
    src_cmd_v = 3'b100;
    settle();
    chk("fp_c3_cmd", f_cmd, 16'h00C0);
    chk("fp_c3_rdy", f_cmd_rdy, 3'b100);
    tick();
    src_cmd_v = 3'b000;
    settle();
    chk("fp_idle_v", f_cmd_v, 1'b0);
    chk("fp_out", f_out, 3'd4);
    do_reset();

    // Round robin: grants 0,1,2,0,1,2 with responses trailing by one cycle
    src_en = 3'b111;
    for (int c = 0; c < 6; c++) begin
      src_cmd_v = 3'b111; io_cmd_ready = 1'b1; src_resp_ready = 3'b111;
      io_resp_v = (c > 0); io_resp = 16'h5500;
      settle();
      chk("rr_cmd", r_cmd, exp_msg[c % 3]);
      chk("rr_rdy", r_cmd_rdy, 3'b001 << (c % 3));
      chk("rr_resp_v", r_resp_v, (c > 0) ? (3'b001 << ((c + 2) % 3)) : 3'b000);
      chk("rr_yumi", r_yumi, (c > 0) ? 1'b1 : 1'b0);
      tick();
    end
    src_cmd_v = 3'b000; io_resp_v = 1'b1; io_resp = 16'h1234;
    settle();
    chk("rr_last_resp_v", r_resp_v, 3'b100);
    chk("rr_last_yumi", r_yumi, 1'b1);
    chk("rr_resp_data", r_resp[2*W +: W], 16'h1234);
    chk("rr_idle_cmd_v", r_cmd_v, 1'b0);
    tick();
    io_resp_v = 1'b0;
    settle();
    chk("rr_drained_out", r_out, 2'd0);
    chk("rr_no_err", r_err, 1'b0);
    do_reset();

    // Tracker full: two accepts, then blocked; a retire unblocks only next cycle
    src_en = 3'b111; src_cmd_v = 3'b001; io_cmd_ready = 1'b1;
    settle();
    chk("full_a0_v", r_cmd_v, 1'b1);
    tick();
    settle();
    chk("full_a1_rdy", r_cmd_rdy, 3'b001);
    tick();
    settle();
    chk("full_blk_v", r_cmd_v, 1'b0);
    chk("full_blk_rdy", r_cmd_rdy, 3'b000);
    chk("full_out2", r_out, 2'd2);
    tick();
    io_resp_v = 1'b1; src_resp_ready = 3'b001;
    settle();
    chk("full_resp_v", r_resp_v, 3'b001);
    chk("full_yumi", r_yumi, 1'b1);
    chk("full_no_bypass", r_cmd_v, 1'b0);
    tick();
    io_resp_v = 1'b0;
    settle();
    chk("full_out1", r_out, 2'd1);
    chk("full_reopen_v", r_cmd_v, 1'b1);
    tick();
    settle();
    chk("full_refill_out", r_out, 2'd2);
    chk("full_refill_v", r_cmd_v, 1'b0);
    do_reset();

    // Backpressure: src 1 granted and stalled, src 0 raises valid mid-stall
    src_en = 3'b111; src_cmd_v = 3'b001; io_cmd_ready = 1'b1;
    settle();
    tick();
    src_cmd_v = 3'b010; io_cmd_ready = 1'b0;
    settle();
    chk("bp_s0_cmd", r_cmd, 16'h00B0);
    chk("bp_s0_v", r_cmd_v, 1'b1);
    chk("bp_s0_rdy", r_cmd_rdy, 3'b000);
    chk("bp_s0_fp_cmd", f_cmd, 16'h00B0);
    tick();
    for (int k = 0; k < 4; k++) begin
      src_cmd_v = 3'b011;
      settle();
      chk("bp_hold_cmd", r_cmd, 16'h00B0);
      chk("bp_hold_fp_cmd", f_cmd, 16'h00B0);
      tick();
    end
    io_cmd_ready = 1'b1;
    settle();
    chk("bp_acc_cmd", r_cmd, 16'h00B0);
    chk("bp_acc_rdy", r_cmd_rdy, 3'b010);
    chk("bp_acc_fp_rdy", f_cmd_rdy, 3'b010);
    tick();
    src_cmd_v = 3'b000; io_cmd_ready = 1'b0;
    settle();
    chk("bp_out", r_out, 2'd2);
    chk("bp_fp_out", f_out, 3'd2);
    do_reset();

    // Enable handoff: disabled source is never granted; enabling grants same cycle
    src_en = 3'b010; src_cmd_v = 3'b001; io_cmd_ready = 1'b1;
    settle();
    chk("en_off_v", r_cmd_v, 1'b0);
    chk("en_off_rdy", r_cmd_rdy, 3'b000);
    chk("en_off_fp_v", f_cmd_v, 1'b0);
    tick();
    src_en = 3'b001;
    settle();
    chk("en_on_v", r_cmd_v, 1'b1);
    chk("en_on_cmd", r_cmd, 16'h00A0);
    chk("en_on_rdy", r_cmd_rdy, 3'b001);
    tick();
    src_cmd_v = 3'b000;
    do_reset();

    // Response with empty tracker: no yumi, sticky error until reset
    src_en = 3'b111; io_resp_v = 1'b1; src_resp_ready = 3'b111;
    settle();
    chk("err_yumi", r_yumi, 1'b0);
    chk("err_resp_v", r_resp_v, 3'b000);
    chk("err_not_yet", r_err, 1'b0);
    tick();
    io_resp_v = 1'b0;
    settle();
    chk("err_set", r_err, 1'b1);
    tick();
    settle();
    chk("err_held", r_err, 1'b1);
    reset = 1'b1;
    tick();
    chk("err_cleared", r_err, 1'b0);
    reset = 1'b0;

    // Response in the same cycle as the first enqueue is not bypassed
    src_cmd_v = 3'b001; io_cmd_ready = 1'b1; io_resp_v = 1'b1;
    settle();
    chk("nobyp_yumi", r_yumi, 1'b0);
    chk("nobyp_cmd_v", r_cmd_v, 1'b1);
    tick();
    src_cmd_v = 3'b000; io_resp_v = 1'b0;
    settle();
    chk("nobyp_err", r_err, 1'b1);
    chk("nobyp_out", r_out, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
